femto16_cpu: RTL and testbench

16-bit accumulator/register CPU (femto16 ISA) that is the bus master of the video platform. It fetches instructions and operands over a single 16-bit synchronous-RAM/ROM bus. It yields that bus to the tile and sprite renderers whenever they raise `hold`. Reset vector is 0x8000, which is the ROM region.

---
 rtl/femto16_cpu.sv | 188 ++++++++++++++++++
 tb/tb_femto16_cpu.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/femto16_cpu.sv
// femto16 accumulator/register CPU: single-bus master with a 1-cycle-latency
// synchronous memory and a hold input that parks the CPU at instruction boundaries.
module femto16_cpu (
   input  logic        clk,
   input  logic        reset,
   input  logic        hold,
   output logic        busy,
   output logic [15:0] address,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   output logic        write
);

   localparam logic [4:0] OP_REG    = 5'b00000;
   localparam logic [4:0] OP_IMM16  = 5'b00001;
   localparam logic [4:0] OP_LOAD   = 5'b00010;
   localparam logic [4:0] OP_STORE  = 5'b00011;
   localparam logic [4:0] OP_PUSH   = 5'b01000;
   localparam logic [4:0] OP_POP    = 5'b01001;
   localparam logic [4:0] OP_JSR    = 5'b01010;
   localparam logic [4:0] OP_RTS    = 5'b01011;
   localparam logic [4:0] OP_RESET  = 5'b01111;
   localparam logic [4:0] OP_BRANCH = 5'b10000;
   localparam logic [15:0] RESET_VECTOR = 16'h8000;

   typedef enum logic [1:0] {S_RESET, S_FETCH, S_DECODE, S_EXEC} state_t;

   state_t      state;
   logic [15:0] regs [0:7];
   logic        z_flag;
   logic        c_flag;
   logic [4:0]  ir_opc;
   logic [2:0]  ir_a;
   logic [2:0]  ir_op;

   logic [4:0]  opc;
   logic [2:0]  ra;
   logic [2:0]  rb;
   logic [15:0] ip;
   logic [15:0] sp;
   logic        imm8_form;
   logic        take;

   assign opc       = data_in[15:11];
   assign ra        = data_in[10:8];
   assign rb        = data_in[2:0];
   assign ip        = regs[7];
   assign sp        = regs[6];
   assign imm8_form = (data_in[15:14] == 2'b11);

   // Returns {z, c, result}; MOV passes the old carry through.
   function automatic logic [17:0] alu(input logic [2:0] op, input logic [15:0] a,
                                       input logic [15:0] b, input logic c_in);
      logic [16:0] s;
      case (op)
         3'd0: s = {c_in, b};
         3'd1: s = {1'b0, a} + {1'b0, b};
         3'd2: s = {1'b0, a} - {1'b0, b};
         3'd3: s = {1'b0, a & b};
         3'd4: s = {1'b0, a | b};
         3'd5: s = {1'b0, a ^ b};
         3'd6: s = {1'b0, a} + 17'd1;
         3'd7: s = {1'b0, a} - 17'd1;
      endcase
      return {(s[15:0] == 16'h0000), s[16], s[15:0]};
   endfunction

   // One ALU serves DECODE (reg/imm8 forms) and EXEC (imm16/load forms).
   logic [2:0]  alu_op;
   logic [2:0]  alu_dst;
   logic [15:0] alu_b;
   logic [17:0] alu_res;

   always_comb begin
      alu_dst = ra;
      alu_op  = data_in[6:4];
      alu_b   = regs[rb];
      if (state == S_EXEC) begin
         alu_dst = ir_a;
         alu_op  = ir_op;
         alu_b   = data_in;
      end else if (imm8_form) begin
         alu_op = data_in[13:11];
         alu_b  = {8'h00, data_in[7:0]};
      end
      alu_res = alu(alu_op, regs[alu_dst], alu_b, c_flag);
   end

   always_comb begin
      case (data_in[10:8])
         3'd0:    take = 1'b1;
         3'd1:    take = z_flag;
         3'd2:    take = ~z_flag;
         3'd3:    take = c_flag;
         3'd4:    take = ~c_flag;
         default: take = 1'b0;
      endcase
   end

   always_comb begin
      busy     = (state == S_RESET) | ((state == S_FETCH) & hold);
      address  = 16'h0000;
      data_out = 16'h0000;
      write    = 1'b0;
      case (state)
         S_FETCH: if (!hold) address = ip;
         S_DECODE: begin
            if (!imm8_form) begin
               case (opc)
                  OP_IMM16: address = ip;
                  OP_LOAD:  address = regs[rb];
                  OP_STORE: begin address = regs[rb];    write = 1'b1; data_out = regs[ra]; end
                  OP_PUSH:  begin address = sp - 16'd1;  write = 1'b1; data_out = regs[ra]; end
                  OP_JSR:   begin address = sp - 16'd1;  write = 1'b1; data_out = ip;       end
                  OP_POP, OP_RTS: address = sp;
                  default: ;
               endcase
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_RESET;
         for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
         regs[7] <= RESET_VECTOR;
         z_flag  <= 1'b0;
         c_flag  <= 1'b0;
         ir_opc  <= 5'd0;
         ir_a    <= 3'd0;
         ir_op   <= 3'd0;
      end else begin
         case (state)
            S_RESET: state <= S_FETCH;
            S_FETCH: begin
               if (!hold) begin
                  regs[7] <= ip + 16'd1;
                  state   <= S_DECODE;
               end
            end
            S_DECODE: begin
               ir_opc <= opc;
               ir_a   <= ra;
               ir_op  <= data_in[6:4];
               state  <= S_FETCH;
               if (imm8_form || opc == OP_REG) begin
                  regs[ra] <= alu_res[15:0];
                  z_flag   <= alu_res[17];
                  c_flag   <= alu_res[16];
               end else begin
                  case (opc)
                     OP_IMM16: begin regs[7] <= ip + 16'd1; state <= S_EXEC; end
                     OP_LOAD:  state <= S_EXEC;
                     OP_BRANCH: if (take) regs[7] <= ip + {{8{data_in[7]}}, data_in[7:0]};
                     OP_PUSH:  regs[6] <= sp - 16'd1;
                     OP_POP:   begin regs[6] <= sp + 16'd1; state <= S_EXEC; end
                     OP_JSR:   begin regs[6] <= sp - 16'd1; regs[7] <= regs[ra]; end
                     OP_RTS:   begin regs[6] <= sp + 16'd1; state <= S_EXEC; end
                     OP_RESET: begin
                        regs[7] <= RESET_VECTOR;
                        z_flag  <= 1'b0;
                        c_flag  <= 1'b0;
                        state   <= S_RESET;
                     end
                     default: ;
                  endcase
               end
            end
            S_EXEC: begin
               state <= S_FETCH;
               case (ir_opc)
                  OP_IMM16, OP_LOAD: begin
                     regs[ir_a] <= alu_res[15:0];
                     z_flag     <= alu_res[17];
                     c_flag     <= alu_res[16];
                  end
                  OP_POP:  regs[ir_a] <= data_in;
                  OP_RTS:  regs[7]    <= data_in;
                  default: ;
               endcase
            end
         endcase
      end
   end

endmodule

// File: tb/tb_femto16_cpu.sv
// Bench for femto16_cpu: an instruction-level ISA model expands each instruction
// into its expected bus cycles, which are compared cycle by cycle against the DUT.
module tb_femto16_cpu;

   logic        clk;
   logic        reset;
   logic        hold;
   logic        busy;
   logic [15:0] address;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        write;

   femto16_cpu dut (
      .clk      (clk),
      .reset    (reset),
      .hold     (hold),
      .busy     (busy),
      .address  (address),
      .data_in  (data_in),
      .data_out (data_out),
      .write    (write)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int failures;
   int cyc;
   int t8010;
   int t8012;
   bit track;

   logic [15:0] mem   [65536];
   logic [15:0] m_mem [65536];
   logic [15:0] m_r   [8];
   logic        m_z;
   logic        m_c;
   // expected cycle: {care_addr, care_data, busy, write, address, data_out}
   logic [35:0] exp_q [$];
   logic [31:0] wr_log [$];

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [35:0] cy(input logic ca, input logic cd, input logic bsy,
                                      input logic wr, input logic [15:0] ad, input logic [15:0] dat);
      return {ca, cd, bsy, wr, ad, dat};
   endfunction

   task automatic m_alu(input int op, input int dst, input logic [15:0] b);
      int a;
      int r;
      a = int'(m_r[dst]);
      r = 0;
      case (op)
         0: r = int'(b);
         1: begin r = a + int'(b); m_c = (r > 65535); end
         2: begin r = a - int'(b); m_c = (a < int'(b)); end
         3: begin r = a & int'(b); m_c = 1'b0; end
         4: begin r = a | int'(b); m_c = 1'b0; end
         5: begin r = a ^ int'(b); m_c = 1'b0; end
         6: begin r = a + 1; m_c = (a == 65535); end
         default: begin r = a - 1; m_c = (a == 0); end
      endcase
      m_r[dst] = r[15:0];
      m_z = (r[15:0] == 16'h0000);
   endtask

   // Executes one whole instruction and queues its bus cycles.
   task automatic model_exec();
      logic [15:0] ins;
      logic [15:0] ad;
      logic [15:0] v;
      logic [35:0] idle;
      int a, b, top, d;
      bit cond;
      idle = cy(0, 0, 0, 0, 16'h0, 16'h0);
      ins  = m_mem[m_r[7]];
      exp_q.push_back(cy(1, 0, 0, 0, m_r[7], 16'h0));
      m_r[7] = m_r[7] + 16'd1;
      a   = int'(ins[10:8]);
      b   = int'(ins[2:0]);
      top = int'(ins[15:11]);
      if (ins[15:14] == 2'b11) begin
         exp_q.push_back(idle);
         m_alu(int'(ins[13:11]), a, {8'h00, ins[7:0]});
      end else begin
         case (top)
            0: begin exp_q.push_back(idle); m_alu(int'(ins[6:4]), a, m_r[b]); end
            1: begin
               exp_q.push_back(cy(1, 0, 0, 0, m_r[7], 16'h0));
               exp_q.push_back(idle);
               v = m_mem[m_r[7]];
               m_r[7] = m_r[7] + 16'd1;
               m_alu(int'(ins[6:4]), a, v);
            end
            2: begin
               ad = m_r[b];
               exp_q.push_back(cy(1, 0, 0, 0, ad, 16'h0));
               exp_q.push_back(idle);
               m_alu(int'(ins[6:4]), a, m_mem[ad]);
            end
            3: begin
               ad = m_r[b];
               exp_q.push_back(cy(1, 1, 0, 1, ad, m_r[a]));
               m_mem[ad] = m_r[a];
            end
            8: begin
               v = m_r[a];
               m_r[6] = m_r[6] - 16'd1;
               exp_q.push_back(cy(1, 1, 0, 1, m_r[6], v));
               m_mem[m_r[6]] = v;
            end
            9: begin
               ad = m_r[6];
               exp_q.push_back(cy(1, 0, 0, 0, ad, 16'h0));
               exp_q.push_back(idle);
               m_r[6] = m_r[6] + 16'd1;
               m_r[a] = m_mem[ad];
            end
            10: begin
               v  = m_r[7];
               ad = m_r[a];
               m_r[6] = m_r[6] - 16'd1;
               exp_q.push_back(cy(1, 1, 0, 1, m_r[6], v));
               m_mem[m_r[6]] = v;
               m_r[7] = ad;
            end
            11: begin
               ad = m_r[6];
               exp_q.push_back(cy(1, 0, 0, 0, ad, 16'h0));
               exp_q.push_back(idle);
               m_r[6] = m_r[6] + 16'd1;
               m_r[7] = m_mem[ad];
            end
            15: begin
               exp_q.push_back(idle);
               exp_q.push_back(cy(1, 1, 1, 0, 16'h0, 16'h0));
               m_r[7] = 16'h8000;
               m_z = 1'b0;
               m_c = 1'b0;
            end
            16: begin
               exp_q.push_back(idle);
               case (int'(ins[10:8]))
                  0: cond = 1;
                  1: cond = m_z;
                  2: cond = !m_z;
                  3: cond = m_c;
                  4: cond = !m_c;
                  default: cond = 0;
               endcase
               d = int'(ins[7:0]);
               if (d > 127) d = d - 256;
               if (cond) m_r[7] = 16'(int'(m_r[7]) + d);
            end
            default: exp_q.push_back(idle);
         endcase
      end
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic step(input logic h);
      logic [35:0] e;
      logic [15:0] rd;
      hold = h;
      #1;
      if (exp_q.size() == 0) begin
         if (h) exp_q.push_back(cy(0, 0, 1, 0, 16'h0, 16'h0));
         else model_exec();
      end
      e = exp_q.pop_front();
      check("busy", {15'h0, busy}, {15'h0, e[33]});
      check("write", {15'h0, write}, {15'h0, e[32]});
      if (e[35]) check("address", address, e[31:16]);
      if (e[34]) check("data_out", data_out, e[15:0]);
      if (track && address == 16'h8010 && t8010 < 0) t8010 = cyc;
      if (track && address == 16'h8012 && t8012 < 0) t8012 = cyc;
      rd = mem[address];
      if (write) begin
         mem[address] = data_out;
         wr_log.push_back({address, data_out});
      end
      @(posedge clk);
      #1 data_in = rd;
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      hold  = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         #1;
         check("rst_busy", {15'h0, busy}, 16'h0001);
         check("rst_write", {15'h0, write}, 16'h0000);
         check("rst_address", address, 16'h0000);
         check("rst_data_out", data_out, 16'h0000);
         @(negedge clk);
      end
      reset = 1'b0;
      for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
      m_r[7] = 16'h8000;
      m_z = 1'b0;
      m_c = 1'b0;
      exp_q.delete();
      exp_q.push_back(cy(1, 1, 1, 0, 16'h0, 16'h0));
   endtask

   task automatic drain();
      for (int i = 0; i < 8 && exp_q.size() != 0; i++) step(1'b0);
   endtask

   logic [15:0] prog [$];
   logic [31:0] exp_wr [$];

   initial begin
      checks   = 0;
      failures = 0;
      cyc      = 0;
      t8010    = -1;
      t8012    = -1;
      track    = 0;
      reset    = 1'b1;
      hold     = 1'b0;
      data_in  = 16'h0000;

      // Directed program: load/store, counted loop, carry, jsr/rts, push/pop.
      prog = '{16'h0800, 16'h4FFE, 16'h0900, 16'h6000, 16'h1801, 16'hC000, 16'h1001, 16'h0B00,
               16'h6001, 16'h1803, 16'h0A00, 16'h0003, 16'h6000, 16'h6000, 16'h6000, 16'h6000,
               16'h0270, 16'h82FE, 16'h0800, 16'hFFFF, 16'hC801, 16'h8301, 16'hC0AA, 16'h1803,
               16'hD800, 16'h8401, 16'hC0BB, 16'h0E00, 16'h6FFF, 16'h0D00, 16'h8030, 16'h5500,
               16'h4100, 16'h4A00, 16'h1A03, 16'h80FF};
      for (int i = 0; i < 65536; i++) begin mem[i] = 16'h0000; m_mem[i] = 16'h0000; end
      for (int i = 0; i < prog.size(); i++) begin
         mem[16'h8000 + i]   = prog[i];
         m_mem[16'h8000 + i] = prog[i];
      end
      mem[16'h8030]   = 16'h5800;
      m_mem[16'h8030] = 16'h5800;

      @(negedge clk);
      do_reset();
      check("first_cycle_busy", {15'h0, busy}, 16'h0001);
      track = 1;
      cyc   = 0;
      for (int k = 0; k < 130; k++) step(k >= 8 && k < 14);
      track = 0;
      drain();

      check("loop_cycles", 16'(t8012 - t8010), 16'd12);
      exp_wr = '{{16'h6000, 16'h4FFE}, {16'h6001, 16'h4FFE}, {16'h6001, 16'h0000},
                 {16'h6FFE, 16'h8020}, {16'h6FFE, 16'h6000}, {16'h6001, 16'h6000}};
      check("write_count", 16'(wr_log.size()), 16'(exp_wr.size()));
      for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++) begin
         check("write_addr", wr_log[i][31:16], exp_wr[i][31:16]);
         check("write_data", wr_log[i][15:0], exp_wr[i][15:0]);
      end

      // Random memory images executed as code, with random hold.
      for (int seg = 0; seg < 3; seg++) begin
         for (int i = 0; i < 65536; i++) begin
            mem[i]   = 16'($urandom);
            m_mem[i] = mem[i];
         end
         do_reset();
         for (int k = 0; k < 1500; k++) step($urandom_range(0, 99) < 25);
         drain();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
